// File: rtl/cmos_sensor_gen.sv
// ----------------------------------------------------------------------------
// cmos_sensor_gen
//   CMOS camera emulator. Generates camera_vs / camera_hs / camera_data on the
//   pixel clock with the same framing as the real sensor. It stands in for the
//   sensor in simulation and on-board bring-up, so the capture, binarization
//   and CNN path can be run from a known, repeatable image.
//
//   Frame sequence: VBLANK (vs=0) -> VPRE (vs=1) -> V_ACTIVE x { LACT (hs=1),
//   LBLK (hs=0) } -> VPOST (vs=1) -> next frame or IDLE.
//
// Ports
//   camera_pclk  in   1  pixel clock, all logic on the rising edge
//   s_rst        in   1  asynchronous reset, active high
//   enable       in   1  frames are generated while high; a running frame
//                        always completes
//   pattern_sel  in   2  0 column ramp, 1 row ramp, 2 checker, 3 constant
//   fixed_value  in   8  pixel value for pattern 3
//   roi_en       in   1  overlay the ROI test target
//   camera_vs    out  1  high for the whole frame window
//   camera_hs    out  1  high for exactly H_ACTIVE cycles per active line
//   camera_data  out  8  pixel while camera_hs=1, else 8'h00
//   frame_done   out  1  one-cycle pulse on the cycle camera_vs falls
//   frame_cnt    out 16  completed frames, wraps 16'hFFFF -> 0
//   busy         out  1  high in every state except IDLE
// ----------------------------------------------------------------------------
module cmos_sensor_gen #(
    parameter int H_ACTIVE = 752,
    parameter int H_BLANK  = 94,
    parameter int V_ACTIVE = 480,
    parameter int V_BLANK  = 5000,
    parameter int V_PRE    = 40,
    parameter int V_POST   = 40,
    parameter int ROI_X0   = 320,
    parameter int ROI_X1   = 432,
    parameter int ROI_Y0   = 184,
    parameter int ROI_Y1   = 296,
    // inner square of the ROI target, relative to the ROI origin, [lo,hi)
    parameter int ROI_IX0  = 32,
    parameter int ROI_IX1  = 80,
    parameter int ROI_IY0  = 32,
    parameter int ROI_IY1  = 80
) (
    input  logic        camera_pclk,
    input  logic        s_rst,
    input  logic        enable,
    input  logic [1:0]  pattern_sel,
    input  logic [7:0]  fixed_value,
    input  logic        roi_en,
    output logic        camera_vs,
    output logic        camera_hs,
    output logic [7:0]  camera_data,
    output logic        frame_done,
    output logic [15:0] frame_cnt,
    output logic        busy
);

    // Shared blank counter is sized by the longest of the blank phases.
    localparam int MAX_AB  = (V_BLANK > V_PRE)  ? V_BLANK : V_PRE;
    localparam int MAX_CD  = (H_BLANK > V_POST) ? H_BLANK : V_POST;
    localparam int MAX_BLK = (MAX_AB > MAX_CD)  ? MAX_AB  : MAX_CD;
    localparam int CW      = $clog2(MAX_BLK + 1);

    localparam logic [CW-1:0] VBLANK_LAST = CW'(V_BLANK - 1);
    localparam logic [CW-1:0] VPRE_LAST   = CW'(V_PRE - 1);
    localparam logic [CW-1:0] HBLANK_LAST = CW'(H_BLANK - 1);
    localparam logic [CW-1:0] VPOST_LAST  = CW'(V_POST - 1);

    localparam logic [9:0] COL_LAST = 10'(H_ACTIVE - 1);
    localparam logic [9:0] ROW_LAST = 10'(V_ACTIVE - 1);

    localparam logic [9:0] RX0 = 10'(ROI_X0);
    localparam logic [9:0] RX1 = 10'(ROI_X1);
    localparam logic [9:0] RY0 = 10'(ROI_Y0);
    localparam logic [9:0] RY1 = 10'(ROI_Y1);
    localparam logic [9:0] IX0 = 10'(ROI_X0 + ROI_IX0);
    localparam logic [9:0] IX1 = 10'(ROI_X0 + ROI_IX1);
    localparam logic [9:0] IY0 = 10'(ROI_Y0 + ROI_IY0);
    localparam logic [9:0] IY1 = 10'(ROI_Y0 + ROI_IY1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_VBLANK = 3'd1;
    localparam logic [2:0] S_VPRE   = 3'd2;
    localparam logic [2:0] S_LACT   = 3'd3;
    localparam logic [2:0] S_LBLK   = 3'd4;
    localparam logic [2:0] S_VPOST  = 3'd5;

    logic [2:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [9:0]    r_col;
    logic [9:0]    r_row;
    logic [1:0]    r_pat;
    logic [7:0]    r_fix;
    logic          r_roi;
    logic          r_vs;
    logic          r_hs;
    logic [7:0]    r_data;
    logic          r_done;
    logic [15:0]   r_frame_cnt;
    logic          r_busy;

    logic [2:0]    w_nxt_state;
    logic [CW-1:0] w_nxt_cnt;
    logic [9:0]    w_nxt_col;
    logic [9:0]    w_nxt_row;
    logic          w_latch;
    logic          w_frame_end;
    logic [7:0]    w_pat_px;
    logic          w_in_roi;
    logic          w_in_inner;
    logic [7:0]    w_nxt_data;

    // Next-state / counter logic.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt;
        w_nxt_col   = r_col;
        w_nxt_row   = r_row;
        w_latch     = 1'b0;
        w_frame_end = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (enable) begin
                    w_nxt_state = S_VBLANK;
                    w_nxt_cnt   = '0;
                    w_latch     = 1'b1;
                end
            end
            S_VBLANK: begin
                if (r_cnt == VBLANK_LAST) begin
                    w_nxt_state = S_VPRE;
                    w_nxt_cnt   = '0;
                end else begin
                    w_nxt_cnt = r_cnt + 1'b1;
                end
            end
            S_VPRE: begin
                if (r_cnt == VPRE_LAST) begin
                    w_nxt_state = S_LACT;
                    w_nxt_cnt   = '0;
                    w_nxt_col   = '0;
                    w_nxt_row   = '0;
                end else begin
                    w_nxt_cnt = r_cnt + 1'b1;
                end
            end
            S_LACT: begin
                if (r_col == COL_LAST) begin
                    w_nxt_state = S_LBLK;
                    w_nxt_cnt   = '0;
                end else begin
                    w_nxt_col = r_col + 10'd1;
                end
            end
            S_LBLK: begin
                if (r_cnt == HBLANK_LAST) begin
                    w_nxt_cnt = '0;
                    if (r_row != ROW_LAST) begin
                        w_nxt_state = S_LACT;
                        w_nxt_col   = '0;
                        w_nxt_row   = r_row + 10'd1;
                    end else begin
                        w_nxt_state = S_VPOST;
                    end
                end else begin
                    w_nxt_cnt = r_cnt + 1'b1;
                end
            end
            S_VPOST: begin
                if (r_cnt == VPOST_LAST) begin
                    w_nxt_cnt   = '0;
                    w_frame_end = 1'b1;
                    if (enable) begin
                        w_nxt_state = S_VBLANK;
                        w_latch     = 1'b1;
                    end else begin
                        w_nxt_state = S_IDLE;
                    end
                end else begin
                    w_nxt_cnt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_nxt_state = S_IDLE;
                w_nxt_cnt   = '0;
            end
        endcase
    end

    // Pixel for the next cycle. Outputs are registered from the next-state
    // values so vs/hs/data leave the flops together and the first pixel
    // appears on the same cycle as the hs rising edge. The latched controls
    // are only loaded on entry to VBLANK, never next to LACT, so using the
    // registered copies here is safe.
    always_comb begin
        case (r_pat)
            2'd0:    w_pat_px = w_nxt_col[7:0];
            2'd1:    w_pat_px = w_nxt_row[7:0];
            2'd2:    w_pat_px = (w_nxt_col[4] ^ w_nxt_row[4]) ? 8'hFF : 8'h00;
            default: w_pat_px = r_fix;
        endcase

        w_in_roi   = r_roi &&
                     (w_nxt_col >= RX0) && (w_nxt_col < RX1) &&
                     (w_nxt_row >= RY0) && (w_nxt_row < RY1);
        w_in_inner = (w_nxt_col >= IX0) && (w_nxt_col < IX1) &&
                     (w_nxt_row >= IY0) && (w_nxt_row < IY1);

        if (w_nxt_state != S_LACT) begin
            w_nxt_data = 8'h00;
        end else if (w_in_roi) begin
            // dark inner square on a bright surround: binarizes at 8'h80
            w_nxt_data = w_in_inner ? 8'h10 : 8'hF0;
        end else begin
            w_nxt_data = w_pat_px;
        end
    end

    always_ff @(posedge camera_pclk or posedge s_rst) begin
        if (s_rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_col       <= '0;
            r_row       <= '0;
            r_pat       <= '0;
            r_fix       <= '0;
            r_roi       <= 1'b0;
            r_vs        <= 1'b0;
            r_hs        <= 1'b0;
            r_data      <= '0;
            r_done      <= 1'b0;
            r_frame_cnt <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            r_cnt   <= w_nxt_cnt;
            r_col   <= w_nxt_col;
            r_row   <= w_nxt_row;
            if (w_latch) begin
                r_pat <= pattern_sel;
                r_fix <= fixed_value;
                r_roi <= roi_en;
            end
            r_vs   <= (w_nxt_state != S_IDLE) && (w_nxt_state != S_VBLANK);
            r_hs   <= (w_nxt_state == S_LACT);
            r_data <= w_nxt_data;
            r_done <= w_frame_end;
            if (w_frame_end) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
            r_busy <= (w_nxt_state != S_IDLE);
        end
    end

    assign camera_vs   = r_vs;
    assign camera_hs   = r_hs;
    assign camera_data = r_data;
    assign frame_done  = r_done;
    assign frame_cnt   = r_frame_cnt;
    assign busy        = r_busy;

endmodule

// File: tb/tb_cmos_sensor_gen.sv
// ----------------------------------------------------------------------------
// tb_cmos_sensor_gen
//   Bench for cmos_sensor_gen. Line geometry and ROI columns are the real
//   ones; the vertical dimensions and ROI rows are shrunk so several frames
//   fit in a short run.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cmos_sensor_gen;

    localparam int HA    = 752;
    localparam int HB    = 94;
    localparam int VA    = 8;
    localparam int VB    = 30;
    localparam int VP    = 6;
    localparam int VQ    = 5;
    localparam int RX0   = 320;
    localparam int RX1   = 432;
    localparam int RY0   = 2;
    localparam int RY1   = 6;
    localparam int IX0   = 32;
    localparam int IX1   = 80;
    localparam int IY0   = 1;
    localparam int IY1   = 3;
    localparam int LINE  = HA + HB;
    localparam int FRAME = VB + VP + VA * LINE + VQ;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic [1:0]  pattern_sel = 2'd0;
    logic [7:0]  fixed_value = 8'h00;
    logic        roi_en = 1'b0;
    logic        camera_vs;
    logic        camera_hs;
    logic [7:0]  camera_data;
    logic        frame_done;
    logic [15:0] frame_cnt;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    cmos_sensor_gen #(
        .H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA), .V_BLANK(VB),
        .V_PRE(VP), .V_POST(VQ),
        .ROI_X0(RX0), .ROI_X1(RX1), .ROI_Y0(RY0), .ROI_Y1(RY1),
        .ROI_IX0(IX0), .ROI_IX1(IX1), .ROI_IY0(IY0), .ROI_IY1(IY1)
    ) dut (
        .camera_pclk(clk),
        .s_rst(rst),
        .enable(enable),
        .pattern_sel(pattern_sel),
        .fixed_value(fixed_value),
        .roi_en(roi_en),
        .camera_vs(camera_vs),
        .camera_hs(camera_hs),
        .camera_data(camera_data),
        .frame_done(frame_done),
        .frame_cnt(frame_cnt),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: position within the frame (-1 when idle) plus the
    // controls captured at frame start.
    int          m_k = -1;
    logic        m_done = 1'b0;
    logic [15:0] m_frames = '0;
    logic [15:0] cnt_base = '0;
    logic [1:0]  m_pat = '0;
    logic [7:0]  m_fix = '0;
    logic        m_roi = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_k      <= -1;
            m_done   <= 1'b0;
            m_frames <= '0;
        end else begin
            m_done <= 1'b0;
            if (m_k < 0) begin
                if (enable) begin
                    m_k   <= 0;
                    m_pat <= pattern_sel;
                    m_fix <= fixed_value;
                    m_roi <= roi_en;
                end
            end else if (m_k == FRAME - 1) begin
                m_done   <= 1'b1;
                m_frames <= m_frames + 16'd1;
                if (enable) begin
                    m_k   <= 0;
                    m_pat <= pattern_sel;
                    m_fix <= fixed_value;
                    m_roi <= roi_en;
                end else begin
                    m_k <= -1;
                end
            end else begin
                m_k <= m_k + 1;
            end
        end
    end

    function automatic logic [7:0] model_px(input int c, input int r, input logic [1:0] pat,
                                            input logic [7:0] fix, input logic roi);
        int dc;
        int dr;
        dc = c - RX0;
        dr = r - RY0;
        if (roi && c >= RX0 && c < RX1 && r >= RY0 && r < RY1)
            return (dc >= IX0 && dc < IX1 && dr >= IY0 && dr < IY1) ? 8'h10 : 8'hF0;
        case (pat)
            2'd0:    return 8'(c % 256);
            2'd1:    return 8'(r % 256);
            2'd2:    return (((c / 16) + (r / 16)) % 2 == 1) ? 8'hFF : 8'h00;
            default: return fix;
        endcase
    endfunction

    // DUT-side observations used by the stimulus and the timing checks.
    int   hi_len = 0;
    int   lo_len = 0;
    int   lines = 0;
    int   seen_done = 0;
    logic prev_hs = 1'b0;
    logic prev_vs = 1'b0;

    always @(negedge clk) begin : cmp
        logic        evs;
        logic        ehs;
        logic        ebusy;
        logic [7:0]  edata;
        logic [15:0] ecnt;
        int          k;
        int          mrow;
        int          mcol;
        evs = 1'b0; ehs = 1'b0; ebusy = 1'b0; edata = 8'h00;
        mrow = -1; mcol = -1;
        ecnt = cnt_base + m_frames;
        if (m_k >= 0) begin
            ebusy = 1'b1;
            k = m_k - VB;
            if (k >= 0) begin
                evs = 1'b1;
                k = k - VP;
                if (k >= 0 && k < VA * LINE) begin
                    mrow = k / LINE;
                    mcol = k % LINE;
                    if (mcol < HA) begin
                        ehs   = 1'b1;
                        edata = model_px(mcol, mrow, m_pat, m_fix, m_roi);
                    end
                end
            end
        end
        chk("vs", 32'(camera_vs), 32'(evs));
        chk("hs", 32'(camera_hs), 32'(ehs));
        chk("data", 32'(camera_data), 32'(edata));
        chk("frame_done", 32'(frame_done), 32'(m_done));
        chk("frame_cnt", 32'(frame_cnt), 32'(ecnt));
        chk("busy", 32'(busy), 32'(ebusy));

        // Hand-computed pixel expectations pinning the model.
        if (rst) begin
            chk("rst_outputs", {camera_vs, camera_hs, camera_data, frame_done}, 32'd0);
        end
        if (ehs && m_pat == 2'd0 && !m_roi) begin
            if (mrow == 0 && mcol == 751) chk("p0_col751", 32'(camera_data), 32'hEF);
            if (mrow == 1 && mcol == 255) chk("p0_col255", 32'(camera_data), 32'hFF);
            if (mrow == 1 && mcol == 256) chk("p0_col256", 32'(camera_data), 32'h00);
        end
        if (ehs && m_pat == 2'd3 && m_fix == 8'h5A && mrow == 5 && mcol == 100)
            chk("p3_5a", 32'(camera_data), 32'h5A);
        if (ehs && m_pat == 2'd3 && m_fix == 8'h00 && m_roi) begin
            if (mrow == 2 && mcol == 320) chk("roi_corner", 32'(camera_data), 32'hF0);
            if (mrow == 3 && mcol == 352) chk("roi_inner", 32'(camera_data), 32'h10);
            if (mrow == 6 && mcol == 320) chk("roi_row_end", 32'(camera_data), 32'h00);
            if (mrow == 3 && mcol == 319) chk("roi_col_pre", 32'(camera_data), 32'h00);
            if (mrow == 4 && mcol == 431) chk("roi_col_last", 32'(camera_data), 32'hF0);
            if (mrow == 4 && mcol == 399) chk("roi_inner_last", 32'(camera_data), 32'h10);
            if (mrow == 4 && mcol == 400) chk("roi_inner_end", 32'(camera_data), 32'hF0);
        end
        if (ehs && m_pat == 2'd2 && mrow == 0) begin
            if (mcol == 15) chk("chk_c15", 32'(camera_data), 32'h00);
            if (mcol == 16) chk("chk_c16", 32'(camera_data), 32'hFF);
            if (mcol == 32) chk("chk_c32", 32'(camera_data), 32'h00);
        end

        // Line timing measured straight off the DUT outputs.
        if (rst) begin
            hi_len = 0; lo_len = 0; lines = 0;
            prev_hs = 1'b0; prev_vs = 1'b0;
        end else begin
            if (camera_hs) begin
                if (!prev_hs) begin
                    if (lines > 0) chk("hs_gap", 32'(lo_len), 32'(HB));
                    lines++;
                    hi_len = 1;
                end else begin
                    hi_len++;
                end
                lo_len = 0;
            end else begin
                if (prev_hs) chk("hs_width", 32'(hi_len), 32'(HA));
                lo_len++;
            end
            if (prev_vs && !camera_vs) chk("lines_per_frame", 32'(lines), 32'(VA));
            if (!prev_vs && camera_vs) lines = 0;
            if (frame_done) seen_done++;
            prev_hs = camera_hs;
            prev_vs = camera_vs;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_done(input int n, input string name);
        int i;
        i = 0;
        while (seen_done < n && i < FRAME + 500) begin
            step();
            i++;
        end
        chk(name, 32'(seen_done >= n), 32'd1);
        if (seen_done < n) begin
            $display("FAIL %s: timeout waiting for frame_done %0d", name, n);
            $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
            $fatal(1, "timeout");
        end
    endtask

    task automatic wait_lines(input int n, input string name);
        int i;
        i = 0;
        while (!(camera_vs && lines >= n) && i < FRAME + 500) begin
            step();
            i++;
        end
        chk(name, 32'(camera_vs && lines >= n), 32'd1);
    endtask

    initial begin
        #1 rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        enable = 1'b1;
        pattern_sel = 2'd1;

        // Async reset in the middle of an active line.
        wait_lines(2, "wait_lact");
        repeat (100) step();
        chk("pre_rst_hs", 32'(camera_hs), 32'd1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_vs", 32'(camera_vs), 32'd0);
        chk("rst_hs", 32'(camera_hs), 32'd0);
        chk("rst_data", 32'(camera_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        pattern_sel = 2'd0;
        fixed_value = 8'h00;
        roi_en = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("vblank_busy", 32'(busy), 32'd1);
        chk("vblank_vs", 32'(camera_vs), 32'd0);

        // Frame A: pattern 0. Controls for frame B change mid-frame.
        repeat (10) step();
        pattern_sel = 2'd3;
        fixed_value = 8'h5A;
        wait_done(1, "frame_a");
        step();
        fixed_value = 8'h00;
        roi_en = 1'b1;
        wait_done(2, "frame_b");
        step();
        chk("frame_cnt_2", 32'(frame_cnt), 32'd2);
        pattern_sel = 2'd2;
        roi_en = 1'b0;
        wait_done(3, "frame_c");

        // Frame D: enable dropped partway through the frame.
        wait_lines(4, "wait_line4");
        enable = 1'b0;
        wait_done(4, "frame_d");
        repeat (3) step();
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_vs", 32'(camera_vs), 32'd0);
        repeat (200) step();
        chk("done_once", 32'(seen_done), 32'd4);

        // Frame counter wrap.
        @(posedge clk);
        #2 force dut.r_frame_cnt = 16'hFFFF;
        cnt_base = 16'hFFFF - m_frames;
        @(posedge clk);
        #2 release dut.r_frame_cnt;
        chk("cnt_preload", 32'(frame_cnt), 32'hFFFF);
        pattern_sel = 2'd1;
        enable = 1'b1;
        wait_done(5, "frame_e");
        step();
        chk("cnt_wrap", 32'(frame_cnt), 32'd0);
        enable = 1'b0;
        repeat (5) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
